// File: rtl/fp_pkg.sv
// Shared types for the float-to-integer front end: IEEE-754 single layout,
// value classes and the skid buffer states.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp32_t;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  // FP_NORMAL must encode as zero so a cleared entry shows no class flags.
  typedef enum logic [2:0] {
    FP_NORMAL,
    FP_ZERO,
    FP_DENORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  // One buffered word with its class travelling alongside it.
  typedef struct packed {
    fp32_t     word;
    fp_class_t cls;
  } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier: zero, denormal, infinity, NaN or normal.
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t     word,
  output fp_class_t cls
);

  always_comb begin
    if (word.exponent == 8'h00) begin
      cls = (word.mantissa == '0) ? FP_ZERO : FP_DENORM;
    end else if (word.exponent == FP_EXP_MAX) begin
      cls = (word.mantissa == '0) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORMAL;
    end
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Unpacks raw IEEE-754 words into registered sign/exponent/mantissa/class through a
// 2-entry skid buffer, with saturating special-value counters. FP_UNPACK_FTZ_EN flushes denormals.
module fp_unpack_stage
  import fp_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [7:0]       exponent_out,
  output logic [22:0]      mantissa_out,
  output logic             is_zero,
  output logic             is_denorm,
  output logic             is_inf,
  output logic             is_nan,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] nan_count,
  output logic [CNT_W-1:0] inf_count,
  output logic [CNT_W-1:0] denorm_count
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  skid_state_t state_q, state_d;
  fp_entry_t   out_q, skid_q, cap, out_d;
  fp_class_t   raw_cls;
  logic        in_ready_q;
  logic        in_xfer, out_xfer;
  logic        load_out, load_skid, out_from_skid;
  logic [CNT_W-1:0] nan_q, inf_q, denorm_q;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  fp_classify u_classify (
    .word (fp32_t'(in_data)),
    .cls  (raw_cls)
  );

  // Captured entry; counters always see the raw class, even when flushed.
  always_comb begin
    cap.word = fp32_t'(in_data);
    cap.cls  = raw_cls;
`ifdef FP_UNPACK_FTZ_EN
    if (raw_cls == FP_DENORM) begin
      cap.word.exponent = '0;
      cap.word.mantissa = '0;
      cap.cls           = FP_ZERO;
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          load_out = 1'b1;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d       = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign out_d = out_from_skid ? skid_q : cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_out)  out_q  <= out_d;
      if (load_skid) skid_q <= cap;
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr_counts) begin
      nan_q    <= '0;
      inf_q    <= '0;
      denorm_q <= '0;
    end else if (in_xfer) begin
      if (raw_cls == FP_NAN && nan_q != '1)       nan_q    <= nan_q + CntOne;
      if (raw_cls == FP_INF && inf_q != '1)       inf_q    <= inf_q + CntOne;
      if (raw_cls == FP_DENORM && denorm_q != '1) denorm_q <= denorm_q + CntOne;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign sign_out     = out_q.word.sign;
  assign exponent_out = out_q.word.exponent;
  assign mantissa_out = out_q.word.mantissa;
  assign is_zero      = (out_q.cls == FP_ZERO);
  assign is_denorm    = (out_q.cls == FP_DENORM);
  assign is_inf       = (out_q.cls == FP_INF);
  assign is_nan       = (out_q.cls == FP_NAN);
  assign nan_count    = nan_q;
  assign inf_count    = inf_q;
  assign denorm_count = denorm_q;

endmodule

// File: doc/fp_unpack_stage.md
Name: fp_unpack_stage

Overview:
Upstream stage of the float-to-integer converter. Accepts raw IEEE-754 single-precision words on a valid/ready stream. Splits each word into sign, biased exponent and 23-bit mantissa, and classifies it as normal, zero, denormal, infinity or NaN. Presents registered fields through a 2-entry skid buffer, ready to drive the converter's sign/exponent/mantissa inputs, and keeps saturating event counters for special values.

Parameters:
CNT_W, 16, width of each special-value event counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  32  raw IEEE-754 word: [31] sign, [30:23] exponent, [22:0] mantissa
in_valid  input  1  in_data valid
in_ready  output  1  stage can accept in_data this cycle
out_valid  output  1  output fields valid
out_ready  input  1  downstream accepts output this cycle
sign_out  output  1  sign bit
exponent_out  output  8  biased exponent, unmodified
mantissa_out  output  23  fraction field
is_zero  output  1  exponent==0, mantissa==0
is_denorm  output  1  exponent==0, mantissa!=0
is_inf  output  1  exponent==255, mantissa==0
is_nan  output  1  exponent==255, mantissa!=0
clr_counts  input  1  synchronous clear of all counters
nan_count  output  CNT_W  accepted NaN words, saturating
inf_count  output  CNT_W  accepted infinity words, saturating
denorm_count  output  CNT_W  accepted denormal words, saturating

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-high.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Reset values: state EMPTY, out_valid=0, in_ready=0, all payload/class outputs 0, all counters 0.
- in_ready is registered. It goes to 1 on the first cycle after reset deasserts. Thereafter in_ready = (next state != FULL).
- Latency: a word accepted at edge N appears on outputs after edge N when the output register is empty or draining. Throughput is 1 word/cycle with out_ready held high.
- Skid FSM, three states:
  - EMPTY: input transfer -> ONE (word loaded into output register).
  - ONE:
    - input only -> FULL (word loaded into skid register).
    - output only -> EMPTY.
    - both -> ONE (new word loaded into output register).
    - neither -> ONE.
  - FULL (in_ready=0): output transfer -> ONE, skid word moves to output register. Otherwise hold.
- Ordering is strictly FIFO; no word is ever dropped or duplicated.
- While out_valid=1 and out_ready=0, all output fields are held stable.
- Classification: pure function of exponent/mantissa. Exactly one of is_zero/is_denorm/is_inf/is_nan is set, or none for a normal number. Classification travels with its word through the skid register.
- Counters:
  - Increment on input transfer of the matching class.
  - Saturate at all-ones; no wrap.
  - clr_counts has priority over a same-cycle increment: result 0, that event is lost.
- Reset mid-operation: all buffered words are discarded and counters are cleared.

Optional Feature:
Macro FP_UNPACK_FTZ_EN.
- Defined: denormal inputs are flushed to signed zero at capture.
  - mantissa_out=0, exponent_out=0, sign preserved.
  - is_zero=1, is_denorm=0.
  - denorm_count still increments.
- Undefined: denormals pass through unmodified with is_denorm=1.

Decomposition:
- Package fp_pkg holds:
  - typedef fp32_t, a packed struct: sign, exponent[7:0], mantissa[22:0].
  - Constants FP_EXP_BIAS=127, FP_EXP_MAX=8'hFF.
  - enum fp_class_t: FP_NORMAL, FP_ZERO, FP_DENORM, FP_INF, FP_NAN.
  - enum skid_state_t: EMPTY, ONE, FULL.
- One sub-module: fp_classify. Combinational, takes fp32_t and returns fp_class_t. Instantiated once at capture.

Test Plan:
- in_data=0x3F800000, out_ready=1 -> next cycle out_valid=1, sign_out=0, exponent_out=0x7F, mantissa_out=0, all class flags 0.
- Back-to-back 0x7FC00000, 0xFF800000, 0x80000000 -> NaN, inf (sign 1), zero (sign 1) in order; nan_count=1, inf_count=1, denorm_count=0.
- out_ready=0, offer 3 words 0x40000000/0x40400000/0x40800000 -> first two accepted, in_ready=0 while third offered; release out_ready -> 3 words delivered in order, no drops.
- in_data=0x00000001 -> without FTZ: is_denorm=1, mantissa_out=1. With FP_UNPACK_FTZ_EN: is_zero=1, mantissa_out=0. denorm_count=1 both cases.
- CNT_W=2, 5 NaNs -> nan_count saturates at 3. clr_counts asserted with a 6th NaN in the same cycle -> nan_count=0.
- Reach FULL, assert reset one cycle -> out_valid=0, counters 0. in_ready=0 during reset, then 1 the next cycle.
